// File: rtl/adc_channel_monitor.sv
// adc_channel_monitor
// Per-channel health and statistics monitor for the LTC2387 ADC array.
// It keeps a saturating count of missing-DCO events and of test-pattern
// mismatches for each channel. It also tracks the signed min/max of each
// channel over a window of 2**WIN_LOG2 sample strobes.
// At the end of each window the results are latched into snapshot registers
// and win_strobe pulses for one cycle.
// Optional feature macro: ADC_MON_ALARM_EN adds the alarm_lo/alarm_hi inputs
// and a sticky per-channel range alarm. When the macro is undefined, alarm is
// tied to 0.
module adc_channel_monitor #(
  parameter int NUM_ADC  = 16,
  parameter int DATA_W   = 18,
  parameter int CNT_W    = 16,
  parameter int WIN_LOG2 = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            reset_counters,
  input  logic                            adc_valid,
  input  logic [NUM_ADC-1:0]              adc_ch_valid,
  input  logic [NUM_ADC-1:0][DATA_W-1:0]  adc_data,
  input  logic                            testpat_en,
  input  logic [DATA_W-1:0]               testpat_value,
`ifdef ADC_MON_ALARM_EN
  input  logic signed [DATA_W-1:0]        alarm_lo,
  input  logic signed [DATA_W-1:0]        alarm_hi,
`endif
  output logic [NUM_ADC-1:0][CNT_W-1:0]   bad_dco_counter,
  output logic [NUM_ADC-1:0][CNT_W-1:0]   bad_data_counter,
  output logic [NUM_ADC-1:0][DATA_W-1:0]  win_min,
  output logic [NUM_ADC-1:0][DATA_W-1:0]  win_max,
  output logic [NUM_ADC-1:0]              win_empty,
  output logic                            win_strobe,
  output logic [NUM_ADC-1:0]              alarm
);

  localparam logic [WIN_LOG2-1:0] SCNT_MAX = {WIN_LOG2{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  // State registers
  logic                            tp_q, tp_d;
  logic [WIN_LOG2-1:0]             scnt_q, scnt_d;
  logic [NUM_ADC-1:0]              seen_q, seen_d;
  logic [NUM_ADC-1:0][DATA_W-1:0]  run_min_q, run_min_d;
  logic [NUM_ADC-1:0][DATA_W-1:0]  run_max_q, run_max_d;
  logic [NUM_ADC-1:0][CNT_W-1:0]   dco_cnt_q, dco_cnt_d;
  logic [NUM_ADC-1:0][CNT_W-1:0]   dat_cnt_q, dat_cnt_d;
  logic [NUM_ADC-1:0][DATA_W-1:0]  win_min_q, win_min_d;
  logic [NUM_ADC-1:0][DATA_W-1:0]  win_max_q, win_max_d;
  logic [NUM_ADC-1:0]              win_empty_q, win_empty_d;
  logic                            win_strobe_q, win_strobe_d;
  logic [NUM_ADC-1:0]              alarm_q, alarm_d;

  // Combinational helpers
  logic                            tp_edge;
  logic                            stat_en;
  logic                            win_close;
  logic [NUM_ADC-1:0]              samp_ok;
  logic [NUM_ADC-1:0]              seen_m;
  logic [NUM_ADC-1:0][DATA_W-1:0]  min_m;
  logic [NUM_ADC-1:0][DATA_W-1:0]  max_m;
  logic [NUM_ADC-1:0]              out_of_range;

  // Qualify samples and merge the current sample into each channel's running min/max.
  always_comb begin
    tp_edge   = (testpat_en != tp_q);
    stat_en   = adc_valid && !testpat_en && !tp_edge && !reset_counters;
    win_close = stat_en && (scnt_q == SCNT_MAX);
    samp_ok   = '0;
    seen_m    = '0;
    min_m     = '0;
    max_m     = '0;
    for (int n = 0; n < NUM_ADC; n++) begin
      samp_ok[n] = stat_en && adc_ch_valid[n];
      seen_m[n]  = seen_q[n] || samp_ok[n];
      if (samp_ok[n] && !seen_q[n]) begin
        min_m[n] = adc_data[n];
        max_m[n] = adc_data[n];
      end else if (samp_ok[n]) begin
        if ($signed(adc_data[n]) < $signed(run_min_q[n])) begin
          min_m[n] = adc_data[n];
        end else begin
          min_m[n] = run_min_q[n];
        end
        if ($signed(adc_data[n]) > $signed(run_max_q[n])) begin
          max_m[n] = adc_data[n];
        end else begin
          max_m[n] = run_max_q[n];
        end
      end else begin
        min_m[n] = run_min_q[n];
        max_m[n] = run_max_q[n];
      end
    end
  end

`ifdef ADC_MON_ALARM_EN
  // Range comparators used by the sticky alarm.
  always_comb begin
    out_of_range = '0;
    for (int n = 0; n < NUM_ADC; n++) begin
      out_of_range[n] = ($signed(adc_data[n]) < alarm_lo) ||
                        ($signed(adc_data[n]) > alarm_hi);
    end
  end
`else
  assign out_of_range = '0;
`endif

  // Next-state logic for the error counters, the window trackers, the snapshots and the alarm.
  always_comb begin
    tp_d         = testpat_en;
    scnt_d       = scnt_q;
    seen_d       = seen_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    dco_cnt_d    = dco_cnt_q;
    dat_cnt_d    = dat_cnt_q;
    win_min_d    = win_min_q;
    win_max_d    = win_max_q;
    win_empty_d  = win_empty_q;
    win_strobe_d = win_close;
    alarm_d      = alarm_q;

    if (reset_counters) begin
      // The stored test-pattern flag is cleared too, so a still-asserted
      // testpat_en is treated as a fresh edge on the next cycle.
      tp_d      = 1'b0;
      scnt_d    = '0;
      seen_d    = '0;
      run_min_d = '0;
      run_max_d = '0;
      dco_cnt_d = '0;
      dat_cnt_d = '0;
      alarm_d   = '0;
    end else begin
      // Error counters saturate at all-ones and never wrap.
      for (int n = 0; n < NUM_ADC; n++) begin
        if (adc_valid && !adc_ch_valid[n] && (dco_cnt_q[n] != CNT_MAX)) begin
          dco_cnt_d[n] = dco_cnt_q[n] + CNT_W'(1);
        end else begin
          dco_cnt_d[n] = dco_cnt_q[n];
        end
        if (adc_valid && adc_ch_valid[n] && testpat_en &&
            (adc_data[n] != testpat_value) && (dat_cnt_q[n] != CNT_MAX)) begin
          dat_cnt_d[n] = dat_cnt_q[n] + CNT_W'(1);
        end else begin
          dat_cnt_d[n] = dat_cnt_q[n];
        end
      end
      alarm_d = alarm_q | (samp_ok & out_of_range);

      if (tp_edge) begin
        // A mode change restarts the window with no strobe.
        scnt_d    = '0;
        seen_d    = '0;
        run_min_d = '0;
        run_max_d = '0;
      end else if (win_close) begin
        scnt_d    = '0;
        seen_d    = '0;
        run_min_d = '0;
        run_max_d = '0;
        for (int n = 0; n < NUM_ADC; n++) begin
          if (seen_m[n]) begin
            win_min_d[n] = min_m[n];
            win_max_d[n] = max_m[n];
          end else begin
            win_min_d[n] = '0;
            win_max_d[n] = '0;
          end
        end
        win_empty_d = ~seen_m;
      end else if (stat_en) begin
        scnt_d    = scnt_q + WIN_LOG2'(1);
        seen_d    = seen_m;
        run_min_d = min_m;
        run_max_d = max_m;
      end else begin
        scnt_d = scnt_q;
      end
    end
  end

  // State update with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q         <= 1'b0;
      scnt_q       <= '0;
      seen_q       <= '0;
      run_min_q    <= '0;
      run_max_q    <= '0;
      dco_cnt_q    <= '0;
      dat_cnt_q    <= '0;
      win_min_q    <= '0;
      win_max_q    <= '0;
      win_empty_q  <= '0;
      win_strobe_q <= 1'b0;
      alarm_q      <= '0;
    end else begin
      tp_q         <= tp_d;
      scnt_q       <= scnt_d;
      seen_q       <= seen_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      dco_cnt_q    <= dco_cnt_d;
      dat_cnt_q    <= dat_cnt_d;
      win_min_q    <= win_min_d;
      win_max_q    <= win_max_d;
      win_empty_q  <= win_empty_d;
      win_strobe_q <= win_strobe_d;
      alarm_q      <= alarm_d;
    end
  end

  assign bad_dco_counter  = dco_cnt_q;
  assign bad_data_counter = dat_cnt_q;
  assign win_min          = win_min_q;
  assign win_max          = win_max_q;
  assign win_empty        = win_empty_q;
  assign win_strobe       = win_strobe_q;
`ifdef ADC_MON_ALARM_EN
  assign alarm            = alarm_q;
`else
  assign alarm            = '0;
`endif

endmodule

// File: tb/tb_adc_channel_monitor.sv
// Scoreboard bench for adc_channel_monitor (NUM_ADC=4, CNT_W=4, WIN_LOG2=3).
// The driver pushes expected window records and expected state records into
// queues. A monitor pops the records and compares them against the DUT:
// window records are compared when win_strobe rises, and state records are
// compared one cycle after they are pushed.
module tb_adc_channel_monitor;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 reset_counters = 1'b0;
  logic                 adc_valid = 1'b0;
  logic [3:0]           adc_ch_valid = 4'hF;
  logic [3:0][17:0]     adc_data = '0;
  logic                 testpat_en = 1'b0;
  logic [17:0]          testpat_value = 18'h330FC;
  logic signed [17:0]   alarm_lo = -18'sd100;
  logic signed [17:0]   alarm_hi = 18'sd100;
  logic [3:0][3:0]      bad_dco_counter, bad_data_counter;
  logic [3:0][17:0]     win_min, win_max;
  logic [3:0]           win_empty;
  logic                 win_strobe;
  logic [3:0]           alarm;

`ifdef ADC_MON_ALARM_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  adc_channel_monitor #(.NUM_ADC(4), .DATA_W(18), .CNT_W(4), .WIN_LOG2(3)) dut (
    .clk(clk), .rst(rst), .reset_counters(reset_counters), .adc_valid(adc_valid),
    .adc_ch_valid(adc_ch_valid), .adc_data(adc_data), .testpat_en(testpat_en),
    .testpat_value(testpat_value),
`ifdef ADC_MON_ALARM_EN
    .alarm_lo(alarm_lo), .alarm_hi(alarm_hi),
`endif
    .bad_dco_counter(bad_dco_counter), .bad_data_counter(bad_data_counter),
    .win_min(win_min), .win_max(win_max), .win_empty(win_empty),
    .win_strobe(win_strobe), .alarm(alarm));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               due;
    logic [3:0][17:0] wmin;
    logic [3:0][17:0] wmax;
    logic [3:0]       wempty;
  } win_t;

  typedef struct {
    logic [3:0][3:0]  dco;
    logic [3:0][3:0]  dat;
    logic [3:0]       alm;
    bit               chk_win;
    logic [3:0][17:0] wmin;
    logic [3:0][17:0] wmax;
    logic [3:0]       wempty;
  } chk_t;

  win_t win_q[$];
  chk_t chk_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic tp_lvl = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [3:0][17:0] mk(input logic [17:0] a0, input logic [17:0] a1,
                                          input logic [17:0] a2, input logic [17:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic chk_t zero_chk();
    chk_t c;
    c.dco = '0; c.dat = '0; c.alm = '0; c.chk_win = 1'b0;
    c.wmin = '0; c.wmax = '0; c.wempty = '0;
    return c;
  endfunction

  task automatic drive(input logic v, input logic [3:0] cv, input logic [3:0][17:0] d,
                       input logic tp, input logic rc);
    @(negedge clk);
    adc_valid = v; adc_ch_valid = cv; adc_data = d; testpat_en = tp; reset_counters = rc;
  endtask

  task automatic sample(input logic [3:0] cv, input logic [3:0][17:0] d);
    drive(1'b1, cv, d, tp_lvl, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 4'hF, '0, tp_lvl, 1'b0);
  endtask

  task automatic clear();
    drive(1'b0, 4'hF, '0, tp_lvl, 1'b1);
    idle();
  endtask

  // Called right after the window-closing sample has been driven.
  task automatic push_win(input logic [3:0][17:0] mn, input logic [3:0][17:0] mx,
                          input logic [3:0] em);
    win_t w;
    w.due = cyc + 1; w.wmin = mn; w.wmax = mx; w.wempty = em;
    win_q.push_back(w);
  endtask

  task automatic expect_state(input chk_t c);
    idle();
    chk_q.push_back(c);
  endtask

  // Monitor: compare against the queued expectations shortly after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (win_strobe === 1'b1) begin
        if (win_q.size() == 0) begin
          check("unexpected_win_strobe", {127'd0, win_strobe}, 128'd0);
        end else begin
          win_t w;
          w = win_q.pop_front();
          check("win_strobe_cycle", 128'(cyc), 128'(w.due));
          check("win_min", win_min, w.wmin);
          check("win_max", win_max, w.wmax);
          check("win_empty", win_empty, w.wempty);
        end
      end
      if (chk_q.size() > 0) begin
        chk_t c;
        c = chk_q.pop_front();
        check("bad_dco_counter", bad_dco_counter, c.dco);
        check("bad_data_counter", bad_data_counter, c.dat);
        check("alarm", alarm, c.alm);
        if (c.chk_win) begin
          check("win_min_held", win_min, c.wmin);
          check("win_max_held", win_max, c.wmax);
          check("win_empty_held", win_empty, c.wempty);
          check("win_strobe_low", {127'd0, win_strobe}, 128'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_t c;
    logic [17:0] t4 [8];
    t4 = '{-18'sd5, 18'sd7, 18'sd0, 18'h20000, 18'sd3, 18'sd131071, 18'sd2, 18'sd1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Reset state: everything zero.
    c = zero_chk(); c.chk_win = 1'b1;
    expect_state(c);

    // Test 1: ch2 missing DCO for 10 strobes; the 8th strobe closes a window.
    for (int i = 0; i < 10; i++) begin
      sample(4'b1011, '0);
      if (i == 7) push_win('0, '0, 4'b0100);
    end
    c = zero_chk(); c.dco = {4'd0, 4'd10, 4'd0, 4'd0};
    expect_state(c);
    clear();
    c = zero_chk(); c.chk_win = 1'b1; c.wempty = 4'b0100;
    expect_state(c);

    // Test 2: ch0 invalid for 20 strobes, so bad_dco[0] saturates at 15.
    for (int i = 0; i < 20; i++) begin
      sample(4'b1110, '0);
      if (i == 7 || i == 15) push_win('0, '0, 4'b0001);
    end
    c = zero_chk(); c.dco = {4'd0, 4'd0, 4'd0, 4'd15};
    expect_state(c);
    // reset_counters wins over a same-cycle strobe.
    drive(1'b1, 4'b1110, '0, 1'b0, 1'b1);
    c = zero_chk(); c.chk_win = 1'b1; c.wempty = 4'b0001;
    expect_state(c);

    // Test 3: test-pattern mode, ch1 mismatches on 3 of 8 strobes, no window.
    tp_lvl = 1'b1;
    idle();
    for (int i = 0; i < 8; i++) begin
      logic [17:0] v1;
      v1 = (i == 0 || i == 3 || i == 5) ? 18'h330FD : 18'h330FC;
      sample(4'hF, mk(18'h330FC, v1, 18'h330FC, 18'h330FC));
    end
    c = zero_chk(); c.dat = {4'd0, 4'd0, 4'd3, 4'd0};
    expect_state(c);
    tp_lvl = 1'b0;
    idle();
    clear();

    // Test 4: signed extremes on ch0, ch2 invalid for the whole window.
    for (int i = 0; i < 8; i++) begin
      sample(4'b1011, mk(t4[i], 18'sd5, 18'sd77, -18'sd1));
      if (i == 7)
        push_win(mk(18'h20000, 18'sd5, 18'd0, -18'sd1),
                 mk(18'h1FFFF, 18'sd5, 18'd0, -18'sd1), 4'b0100);
    end
    c = zero_chk(); c.dco = {4'd0, 4'd8, 4'd0, 4'd0};
    expect_state(c);

    // Test 5: a testpat_en toggle mid-window restarts the window, and the
    // samples in the edge cycles are kept out of the statistics.
    clear();
    for (int i = 0; i < 3; i++) sample(4'hF, mk(-18'sd1000, 18'sd1000, 18'sd0, -18'sd7));
    tp_lvl = 1'b1;
    sample(4'hF, mk(18'd0, 18'h330FC, 18'h330FC, 18'h330FC));   // 0->1 edge sample
    idle();
    tp_lvl = 1'b0;
    sample(4'hF, mk(-18'sd2000, 18'sd2000, 18'sd5, 18'sd999));  // 1->0 edge sample
    for (int i = 1; i <= 8; i++) begin
      sample(4'b1011, mk(18'(i), -18'(i), 18'd0, 18'sd42));
      if (i == 8)
        push_win(mk(18'sd1, -18'sd8, 18'd0, 18'sd42),
                 mk(18'sd8, -18'sd1, 18'd0, 18'sd42), 4'b0100);
    end
    c = zero_chk(); c.dco = {4'd0, 4'd8, 4'd0, 4'd0}; c.dat = {4'd0, 4'd0, 4'd0, 4'd1};
    expect_state(c);

    // Test 6: range alarm (expected to stay 0 when the feature is not built).
    clear();
    sample(4'hF, mk(18'd0, 18'd0, 18'd0, 18'sd101));
    c = zero_chk(); c.alm = ALM ? 4'b1000 : 4'b0000;
    expect_state(c);
    sample(4'hF, mk(-18'sd100, 18'sd100, 18'd0, 18'd0));
    expect_state(c);
    sample(4'hF, mk(-18'sd101, 18'd0, 18'd0, 18'd0));
    c.alm = ALM ? 4'b1001 : 4'b0000;
    expect_state(c);
    clear();
    c = zero_chk();
    expect_state(c);

    repeat (4) idle();
    check("win_queue_drained", 128'(win_q.size()), 128'd0);
    check("chk_queue_drained", 128'(chk_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
